// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift-register sequencer.
//   - Register mode-select encodings driven onto {s1,s0}.
//   - Command opcode encodings carried on cmd_op.
//   - Sequencer state encoding, also visible on the dbg_state port.
//   - shift_sel(): maps a shift direction to its mode select.
package shift_seq_ctrl_pkg;

  // Mode select of the attached 4-bit universal shift register.
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  // Command opcodes.
  localparam logic [1:0] OP_TX   = 2'b00;
  localparam logic [1:0] OP_RX   = 2'b01;
  localparam logic [1:0] OP_ROT  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // dir = 0 shifts toward bit 0 (right), dir = 1 toward the MSB (left).
  function automatic logic [1:0] shift_sel(input logic dir);
    return dir ? SEL_SHL : SEL_SHR;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_counter.sv
// shift_bit_counter: down-counter that times the shift run.
// Ports:
//   clk      in   clock
//   clear    in   synchronous active-low clear (count -> 0)
//   load     in   load load_val (wins over dec)
//   dec      in   decrement by one; saturates at 0
//   load_val in   CNT_W  value to load
//   count    out  CNT_W  current count
//   last     out  high while count == 1, i.e. in the final shift cycle
module shift_bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (!clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command-driven sequencer for a 4-bit universal shift
// register (select 00 hold, 01 shift right, 10 shift left, 11 load).
//
// A command is latched in IDLE, the register is preset in LOAD (one cycle),
// then cmd_len shift cycles run in SHIFT with the serial fill bit chosen by
// the opcode (TX fills 0, RX fills ser_in, ROT recirculates ser_out). The
// final register value is offered in DONE until taken.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. cmd_ready is high only in IDLE and does not depend on
// cmd_valid; done_valid stays high with done_data stable until done_ready.
//
// Ports:
//   clk, clear            clock; synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op, cmd_dir       opcode (TX/RX/ROT/LOAD_ONLY), 0 = right, 1 = left
//   cmd_len, cmd_data     shift count (0 legal), preset value
//   s1, s0, i_par         register mode select and parallel input
//   msb, lsb              register serial fill inputs
//   reg_q                 register parallel output
//   ser_in, ser_out       serial receive / transmit bit
//   ser_en                high in every shift cycle
//   done_valid/done_ready result handshake, done_data = reg_q
//   dbg_state             current sequencer state
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] i_par,
  output logic             msb,
  output logic             lsb,
  input  logic [WIDTH-1:0] reg_q,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_en,
  output logic             done_valid,
  output logic [WIDTH-1:0] done_data,
  input  logic             done_ready,
  output logic [1:0]       dbg_state
);

  state_t           state;
  state_t           state_next;

  // Command fields captured at acceptance; cmd_* is ignored afterwards.
  logic [1:0]       op_q;
  logic             dir_q;
  logic [CNT_W-1:0] len_q;
  logic [WIDTH-1:0] data_q;

  logic             accept;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_last;
  logic [1:0]       sel;
  logic             fill;

  assign accept = cmd_valid && (state == S_IDLE);

  shift_bit_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .clear    (clear),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (len_q),
    .count    (cnt_val),
    .last     (cnt_last)
  );

  // State register and command capture.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state  <= S_IDLE;
      op_q   <= OP_TX;
      dir_q  <= 1'b0;
      len_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q   <= cmd_op;
        dir_q  <= cmd_dir;
        len_q  <= cmd_len;
        data_q <= cmd_data;
      end
    end
  end

  // Next state and counter control.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) state_next = S_LOAD;
      end
      S_LOAD: begin
        cnt_load = 1'b1;
        if ((op_q == OP_LOAD) || (len_q == '0)) state_next = S_DONE;
        else                                    state_next = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_dec = 1'b1;
        // The count==0 term only guards against an inconsistent counter;
        // normally the run ends on the last flag after exactly len cycles.
        if (cnt_last || (cnt_val == '0)) state_next = S_DONE;
      end
      S_DONE: begin
        if (done_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    sel        = SEL_HOLD;
    ser_en     = 1'b0;
    done_valid = 1'b0;
    cmd_ready  = 1'b0;
    case (state)
      S_IDLE:  cmd_ready = 1'b1;
      S_LOAD:  sel = SEL_LOAD;
      S_SHIFT: begin
        sel    = shift_sel(dir_q);
        ser_en = 1'b1;
      end
      S_DONE:  done_valid = 1'b1;
      default: sel = SEL_HOLD;
    endcase
  end

  assign s1        = sel[1];
  assign s0        = sel[0];
  assign i_par     = data_q;
  assign dbg_state = state;

  // The bit leaving the register is the one at the end being shifted out.
  assign ser_out   = dir_q ? reg_q[WIDTH-1] : reg_q[0];
  assign done_data = reg_q;

  // Fill only the end that receives new data; the other end stays 0.
  always_comb begin
    fill = 1'b0;
    msb  = 1'b0;
    lsb  = 1'b0;
    case (op_q)
      OP_RX:   fill = ser_in;
      OP_ROT:  fill = ser_out;
      default: fill = 1'b0;
    endcase
    if (state == S_SHIFT) begin
      if (dir_q) lsb = fill;
      else       msb = fill;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl with an attached 4-bit universal shift
// register model and a trace-based reference model of the sequencer.
module tb_shift_seq_ctrl;
  import shift_seq_ctrl_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  localparam logic [1:0] TX = 2'd0, RX = 2'd1, ROT = 2'd2, LDO = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_len = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          ser_in = 1'b0;
  logic          done_ready = 1'b0;
  logic          cmd_ready, s1, s0, msb, lsb, ser_out, ser_en, done_valid;
  logic [W-1:0]  i_par, reg_q, done_data;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .s1(s1), .s0(s0), .i_par(i_par), .msb(msb), .lsb(lsb), .reg_q(reg_q),
    .ser_in(ser_in), .ser_out(ser_out), .ser_en(ser_en),
    .done_valid(done_valid), .done_data(done_data), .done_ready(done_ready),
    .dbg_state(dbg_state)
  );

  // Attached shift register (the datapath the sequencer steers).
  always_ff @(posedge clk) begin
    if (!clear) reg_q <= '0;
    else begin
      case ({s1, s0})
        2'b01:   reg_q <= {msb, reg_q[W-1:1]};
        2'b10:   reg_q <= {reg_q[W-2:0], lsb};
        2'b11:   reg_q <= i_par;
        default: reg_q <= reg_q;
      endcase
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_q(input string name, input logic [W-1:0] got[$], input logic [W-1:0] want[$]);
    chk({name, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", name, i), got[i], want[i]);
  endtask

  // ---------------- reference model ----------------
  // On acceptance the model writes out every cycle the command will take
  // (one LOAD cycle, then one entry per shift) with plain arithmetic on an
  // integer register value; the DONE phase lasts until done_ready.
  typedef struct packed {
    logic [1:0]   sel;
    logic         is_shift;
    logic [W-1:0] nxt;    // register value after this cycle
    logic         sout;
    logic         m;
    logic         l;
    logic         sin;
  } cyc_t;

  cyc_t         trace[$];
  logic         m_done = 1'b0;
  logic [W-1:0] m_reg  = '0;
  logic [W-1:0] m_ipar = '0;
  logic [W-1:0] m_steps[$];
  logic [7:0]   rx_bits = '0;

  task automatic build(input logic [1:0] op, input logic dir, input int len, input logic [W-1:0] data);
    cyc_t e;
    int   v, outb, fill;
    m_ipar = data;
    m_steps.delete();
    e = '{sel: 2'b11, is_shift: 1'b0, nxt: data, sout: 1'b0, m: 1'b0, l: 1'b0, sin: 1'b0};
    trace.push_back(e);
    if (op != LDO) begin
      v = int'(data);
      for (int k = 0; k < len; k++) begin
        e.sin = (op == RX) ? rx_bits[k] : 1'($urandom_range(0, 1));
        outb  = dir ? ((v >> (W - 1)) & 1) : (v & 1);
        fill  = (op == TX) ? 0 : (op == RX) ? int'(e.sin) : outb;
        v     = dir ? (((v << 1) & (2**W - 1)) | fill) : ((v >> 1) | (fill << (W - 1)));
        e.sel      = dir ? 2'b10 : 2'b01;
        e.is_shift = 1'b1;
        e.nxt      = v[W-1:0];
        e.sout     = outb[0];
        e.m        = dir ? 1'b0 : fill[0];
        e.l        = dir ? fill[0] : 1'b0;
        trace.push_back(e);
        m_steps.push_back(v[W-1:0]);
      end
    end
  endtask

  always @(posedge clk) begin
    if (!clear) begin
      trace.delete();
      m_done = 1'b0;
      m_reg  = '0;
      m_ipar = '0;
    end else if (trace.size() > 0) begin
      m_reg = trace[0].nxt;
      void'(trace.pop_front());
      if (trace.size() == 0) m_done = 1'b1;
    end else if (m_done) begin
      if (done_ready) m_done = 1'b0;
    end else if (cmd_valid) begin
      build(cmd_op, cmd_dir, int'(cmd_len), cmd_data);
    end
  end

  // Serial receive data: the bit chosen for the current shift cycle.
  always @(posedge clk) begin
    #1;
    if (trace.size() > 0 && trace[0].is_shift) ser_in = trace[0].sin;
    else                                       ser_in = 1'($urandom_range(0, 1));
  end

  // ---------------- per-cycle compare ----------------
  cyc_t         ce;
  logic [1:0]   e_sel, e_st;
  logic         e_en, e_rdy, e_dv, e_m, e_l;
  logic         prev_en = 1'b0;
  int           obs_done_cnt = 0;
  logic [W-1:0] obs_ser[$];
  logic [W-1:0] obs_steps[$];

  always @(negedge clk) begin
    if (chk_on) begin
      e_sel = 2'b00; e_en = 1'b0; e_rdy = 1'b0; e_dv = 1'b0; e_m = 1'b0; e_l = 1'b0;
      ce = '0;
      if (trace.size() > 0) begin
        ce = trace[0];
        e_sel = ce.sel; e_en = ce.is_shift; e_m = ce.m; e_l = ce.l;
        e_st = ce.is_shift ? S_SHIFT : S_LOAD;
      end else if (m_done) begin
        e_dv = 1'b1; e_st = S_DONE;
      end else begin
        e_rdy = 1'b1; e_st = S_IDLE;
      end
      chk("sel", {s1, s0}, e_sel);
      chk("ser_en", ser_en, e_en);
      chk("cmd_ready", cmd_ready, e_rdy);
      chk("done_valid", done_valid, e_dv);
      chk("state", dbg_state, e_st);
      chk("reg_q", reg_q, m_reg);
      chk("i_par", i_par, m_ipar);
      chk("msb", msb, e_m);
      chk("lsb", lsb, e_l);
      if (e_en) chk("ser_out", ser_out, ce.sout);
      if (e_dv) chk("done_data", done_data, m_reg);
      if (done_valid === 1'b1) obs_done_cnt++;
      if (ser_en === 1'b1) obs_ser.push_back({{(W-1){1'b0}}, ser_out});
      if (prev_en) obs_steps.push_back(reg_q);
      prev_en = (ser_en === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(output int waited);
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
      waited++;
      if (waited > 60) begin
        n_vec++; n_fail++;
        $display("FAIL accept_timeout: cmd_ready low for %0d cycles, want high", waited);
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_dir   = 1'($urandom);
    cmd_len   = CW'($urandom);
    cmd_data  = W'($urandom);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic dir, input logic [CW-1:0] len, input logic [W-1:0] data);
    int w;
    cmd_op = op; cmd_dir = dir; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    wait_accept(w);
  endtask

  // Counts cycles after the accepting edge; the LOAD cycle is cycle 1.
  task automatic wait_done(output logic [W-1:0] data, output int lat);
    lat = 0; data = '0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done_valid === 1'b1) begin data = done_data; break; end
      if (lat > 40) begin
        n_vec++; n_fail++;
        $display("FAIL done_timeout: done_valid low for %0d cycles, want high", lat);
        break;
      end
    end
  endtask

  task automatic ack_done();
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  task automatic clear_obs();
    obs_ser.delete();
    obs_steps.delete();
  endtask

  // ---------------- directed stimulus ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] d;
  int           lat, waited, base;

  initial begin
    clear = 1'b0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_sel", {s1, s0}, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_ser_en", ser_en, 0);
    chk("rst_i_par", i_par, 0);
    chk("rst_reg_q", reg_q, 0);
    @(posedge clk); #1;
    clear = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 1: TX right len 4 from 1011
    clear_obs();
    send_cmd(TX, 1'b0, 3'd4, 4'b1011);
    wait_done(d, lat);
    chk("t1_latency", lat, 6);
    chk("t1_done_data", d, 4'b0000);
    chk("t1_model_final", m_reg, 4'b0000);
    ack_done();
    exp_q = '{4'd1, 4'd1, 4'd0, 4'd1};
    cmp_q("t1_ser_out", obs_ser, exp_q);

    // 2: RX left len 4, ser_in 1,0,0,1
    clear_obs();
    rx_bits = 8'b0000_1001;
    send_cmd(RX, 1'b1, 3'd4, 4'b0000);
    wait_done(d, lat);
    chk("t2_latency", lat, 6);
    chk("t2_done_data", d, 4'b1001);
    ack_done();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1001};
    cmp_q("t2_steps", obs_steps, exp_q);
    cmp_q("t2_model_steps", m_steps, exp_q);

    // 3: ROT right len 5 from 0001 (wraps past WIDTH)
    clear_obs();
    send_cmd(ROT, 1'b0, 3'd5, 4'b0001);
    wait_done(d, lat);
    chk("t3_latency", lat, 7);
    chk("t3_done_data", d, 4'b1000);
    ack_done();
    exp_q = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    cmp_q("t3_steps", obs_steps, exp_q);
    cmp_q("t3_model_steps", m_steps, exp_q);

    // 4: LOAD_ONLY (len ignored), then TX with len 0
    clear_obs();
    send_cmd(LDO, 1'b0, 3'd3, 4'b0110);
    wait_done(d, lat);
    chk("t4a_latency", lat, 2);
    chk("t4a_done_data", d, 4'b0110);
    ack_done();
    send_cmd(TX, 1'b1, 3'd0, 4'b0101);
    wait_done(d, lat);
    chk("t4b_latency", lat, 2);
    chk("t4b_done_data", d, 4'b0101);
    ack_done();
    chk("t4_no_ser_en", obs_ser.size(), 0);

    // 5: result held back 3 extra cycles while a new command waits
    clear_obs();
    send_cmd(TX, 1'b1, 3'd2, 4'b0110);
    cmd_op = ROT; cmd_dir = 1'b1; cmd_len = 3'd3; cmd_data = 4'b1001; cmd_valid = 1'b1;
    wait_done(d, lat);
    chk("t5a_latency", lat, 4);
    chk("t5a_done_data", d, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", done_valid, 1);
      chk("t5_hold_data", done_data, 4'b1000);
      chk("t5_hold_ready", cmd_ready, 0);
      chk("t5_hold_sel", {s1, s0}, 0);
    end
    ack_done();
    wait_accept(waited);
    chk("t5_accept_wait", waited, 0);
    wait_done(d, lat);
    chk("t5b_latency", lat, 5);
    chk("t5b_done_data", d, 4'b1100);
    ack_done();

    // 6: reset during the second shift cycle aborts the command
    clear_obs();
    send_cmd(ROT, 1'b0, 3'd4, 4'b0110);
    @(posedge clk); #1;          // first SHIFT cycle
    @(posedge clk); #1;          // second SHIFT cycle
    clear = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_done_valid", done_valid, 0);
    chk("t6_sel", {s1, s0}, 0);
    chk("t6_reg_q", reg_q, 4'b0000);
    base = obs_done_cnt;
    repeat (8) @(negedge clk);
    chk("t6_no_done", obs_done_cnt, base);
    @(posedge clk); #1;

    // 7: TX left len 7 (beyond WIDTH) from 1111
    clear_obs();
    send_cmd(TX, 1'b1, 3'd7, 4'b1111);
    wait_done(d, lat);
    chk("t7_latency", lat, 9);
    chk("t7_done_data", d, 4'b0000);
    ack_done();
    exp_q = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
    cmp_q("t7_ser_out", obs_ser, exp_q);

    // 8: RX right len 6, ser_in 1,1,0,1,0,1
    clear_obs();
    rx_bits = 8'b0010_1011;
    send_cmd(RX, 1'b0, 3'd6, 4'b0000);
    wait_done(d, lat);
    chk("t8_latency", lat, 8);
    chk("t8_done_data", d, 4'b1010);
    ack_done();
    exp_q = '{4'b1000, 4'b1100, 4'b0110, 4'b1011, 4'b0101, 4'b1010};
    cmp_q("t8_steps", obs_steps, exp_q);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
